// File: rtl/bram_row_loader.sv
// Streams 32-bit pixel words into a NUM_ROWS-deep circular row buffer in BRAM and
// hands sliding windows to bram_dm via go/done. Define BRAM_LOADER_PATTERN_EN to write address-as-data.
module bram_row_loader #(
  parameter int ROW_WORDS = 640,
  parameter int NUM_ROWS  = 7
) (
  input  logic        clka,
  input  logic        reset,
  input  logic        s_valid,
  input  logic [31:0] s_data,
  input  logic        s_last,
  output logic        s_ready,
  output logic        ena,
  output logic [3:0]  wea,
  output logic [31:0] addra,
  output logic [31:0] dina,
  output logic        go,
  input  logic        done,
  output logic [2:0]  row_base,
  output logic        frame_done,
  output logic        busy
);

  localparam int CW = (ROW_WORDS > 1) ? $clog2(ROW_WORDS) : 1;
  localparam logic [CW-1:0] COL_LAST  = CW'(ROW_WORDS - 1);
  localparam logic [2:0]    ROW_LAST  = 3'(NUM_ROWS - 1);

  typedef enum logic [1:0] {IDLE, FILL, WAIT_DM, SLIDE} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] col, col_nx;
  logic [2:0]    row_wr, row_wr_nx;
  logic [2:0]    rows_filled, rows_filled_nx;
  logic [2:0]    row_base_nx;
  logic          go_nx, fd_nx;
  logic          last_pend, last_pend_nx;
  logic          restart;
  logic          accept, row_end;
  logic [31:0]   wr_addr;

  function automatic logic [2:0] row_inc(input logic [2:0] v);
    return (v == ROW_LAST) ? 3'd0 : v + 3'd1;
  endfunction

  assign s_ready = !reset && (state != WAIT_DM);
  assign accept  = s_valid && s_ready;
  assign busy    = (state != IDLE);
  assign row_end = (col == COL_LAST);
  assign wr_addr = 32'(row_wr) * 32'(ROW_WORDS) + 32'(col);

  always_comb begin
    state_nx       = state;
    col_nx         = col;
    row_wr_nx      = row_wr;
    rows_filled_nx = rows_filled;
    row_base_nx    = row_base;
    go_nx          = go;
    fd_nx          = 1'b0;
    last_pend_nx   = last_pend;
    restart        = 1'b0;

    case (state)
      IDLE, FILL, SLIDE: begin
        if (accept) begin
          if (row_end) begin
            col_nx    = '0;
            row_wr_nx = row_inc(row_wr);
          end else begin
            col_nx = col + 1'b1;
          end
          if (state == SLIDE) begin
            if (row_end) begin
              state_nx     = WAIT_DM;
              row_base_nx  = row_inc(row_base);
              last_pend_nx = s_last;
            end else if (s_last) begin
              restart = 1'b1;
            end
          end else begin
            // A row-completing s_last that also completes the window still gets processed.
            if (row_end && (rows_filled == ROW_LAST)) begin
              state_nx     = WAIT_DM;
              last_pend_nx = s_last;
            end else if (s_last) begin
              restart = 1'b1;
            end else begin
              state_nx = FILL;
              if (row_end) rows_filled_nx = rows_filled + 3'd1;
            end
          end
        end
      end
      WAIT_DM: begin
        // go rises one cycle after entry, i.e. the cycle after the final write is on the port.
        if (go && done) begin
          go_nx = 1'b0;
          if (last_pend) restart  = 1'b1;
          else           state_nx = SLIDE;
        end else begin
          go_nx = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase

    if (restart) begin
      state_nx       = IDLE;
      col_nx         = '0;
      row_wr_nx      = '0;
      rows_filled_nx = '0;
      row_base_nx    = '0;
      last_pend_nx   = 1'b0;
      go_nx          = 1'b0;
      fd_nx          = 1'b1;
    end
  end

  always_ff @(posedge clka) begin
    if (reset) begin
      state       <= IDLE;
      col         <= '0;
      row_wr      <= '0;
      rows_filled <= '0;
      row_base    <= '0;
      go          <= 1'b0;
      frame_done  <= 1'b0;
      last_pend   <= 1'b0;
    end else begin
      state       <= state_nx;
      col         <= col_nx;
      row_wr      <= row_wr_nx;
      rows_filled <= rows_filled_nx;
      row_base    <= row_base_nx;
      go          <= go_nx;
      frame_done  <= fd_nx;
      last_pend   <= last_pend_nx;
    end
  end

  always_ff @(posedge clka) begin
    if (reset) begin
      ena   <= 1'b0;
      wea   <= '0;
      addra <= '0;
      dina  <= '0;
    end else if (accept) begin
      ena   <= 1'b1;
      wea   <= '1;
      addra <= wr_addr;
`ifdef BRAM_LOADER_PATTERN_EN
      dina  <= wr_addr;
`else
      dina  <= s_data;
`endif
    end else begin
      ena <= 1'b0;
      wea <= '0;
    end
  end

endmodule

// File: doc/bram_row_loader.md
BRAM_ROW_LOADER -- requirements
Module: bram_row_loader

Interface
REQ-001 SHALL have parameter ROW_WORDS, default 640, meaning 32-bit words per image row.
REQ-002 SHALL have parameter NUM_ROWS, default 7, meaning rows held in BRAM (window depth); legal range 2..7.
REQ-003 SHALL have port clka  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port s_valid  input  1  upstream word valid.
REQ-006 SHALL have port s_data  input  32  upstream pixel word.
REQ-007 SHALL have port s_last  input  1  marks final word of frame.
REQ-008 SHALL have port s_ready  output  1  loader accepts word this cycle.
REQ-009 SHALL have port ena, wea  output  1, 4  BRAM port-A enable, byte write enables.
REQ-010 SHALL have port addra, dina  output  32, 32  BRAM port-A address, write data.
REQ-011 SHALL have port go  output  1  window ready for bram_dm.
REQ-012 SHALL have port done  input  1  bram_dm finished current window.
REQ-013 SHALL have port row_base  output  3  BRAM row index holding oldest (top) window row.
REQ-014 SHALL have port frame_done, busy  output  1, 1  one-cycle end-of-frame pulse; loader not IDLE.

Function
REQ-015 SHALL implement states IDLE, FILL, WAIT_DM, SLIDE.
REQ-016 A beat SHALL be accepted when s_valid && s_ready; s_ready=1 only in IDLE, FILL, SLIDE.
REQ-017 Accepted beat at edge N SHALL drive ena=1, wea=4'b1111, addra=row_wr*ROW_WORDS+col, dina=s_data during cycle N+1 (registered, latency 1); otherwise ena=0, wea=0, addra/dina hold.
REQ-018 col SHALL count 0..ROW_WORDS-1 and wrap to 0; on wrap row_wr SHALL increment modulo NUM_ROWS (NUM_ROWS-1 -> 0).
REQ-019 IDLE -> FILL on first accepted beat (that beat is written).
REQ-020 FILL: after NUM_ROWS complete rows written, SHALL go to WAIT_DM and assert go the cycle after the last write cycle.
REQ-021 WAIT_DM: go SHALL stay high until done sampled high; next cycle go=0 and state -> SLIDE; s_ready=0 throughout WAIT_DM.
REQ-022 SLIDE: one row SHALL overwrite row row_base; on row completion row_base SHALL increment modulo NUM_ROWS, state -> WAIT_DM, go asserted as in REQ-020.
REQ-023 s_last on a beat completing a row SHALL, after that row's window is processed (done seen), pulse frame_done and return to IDLE with row_base=0, row_wr=0, col=0.
REQ-024 s_last mid-row, or before NUM_ROWS rows filled, SHALL write that beat, discard the partial row/window, issue no go, pulse frame_done, return to IDLE.
REQ-025 done asserted outside WAIT_DM SHALL be ignored.
REQ-026 addra arithmetic SHALL be unsigned 32-bit; upper bits beyond row_wr*ROW_WORDS+col are zero.
REQ-027 busy SHALL be 1 in every state except IDLE.

Reset
REQ-028 reset SHALL take priority over all inputs, including mid-row and during WAIT_DM.
REQ-029 On reset: state=IDLE, s_ready=0 for that cycle, ena=0, wea=0, addra=0, dina=0, go=0, row_base=0, frame_done=0, busy=0, counters=0.
REQ-030 Words accepted before reset SHALL not be re-emitted after reset.

Configuration
REQ-031 Macro BRAM_LOADER_PATTERN_EN SHALL, when defined, replace dina with the 32-bit address value (dina=addra) for every write, ignoring s_data; handshake and timing unchanged.
REQ-032 Without BRAM_LOADER_PATTERN_EN, dina SHALL equal accepted s_data.

Verification
REQ-033 ROW_WORDS=640, NUM_ROWS=7, 4480 continuous beats s_data=index -> addra 0..4479 with dina=addra, go rises cycle after write of addr 4479, row_base=0.
REQ-034 Hold done=0 for 50 cycles in WAIT_DM with s_valid=1 -> s_ready=0, ena=0, go stays 1; done=1 -> go=0 next cycle.
REQ-035 After first window, 640 more beats -> writes addr 0..639, go reasserted, row_base=1; repeat 7 slides -> row_base wraps 6 -> 0.
REQ-036 s_last on beat 100 of row 3 -> no go, frame_done one-cycle pulse, busy=0, next beat writes addra=0.
REQ-037 reset at beat 2000 -> all outputs at reset values next cycle; subsequent frame starts at addra=0.
REQ-038 With BRAM_LOADER_PATTERN_EN, s_data=32'hDEADBEEF constant -> dina at addra 252 equals 252.
